// File: rtl/matrix_tile_gather.sv
// rtl/matrix_tile_gather.sv - double-banked row-serial tile assembler feeding the transpose stage
module matrix_tile_gather #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_MG     = 8,
  parameter int NUM_PE     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [DATA_WIDTH-1:0]         in_row [0:NUM_PE-1],
  input  logic                          in_transpose,
  input  logic                          in_val,
  output logic                          in_rdy,
  output logic [DATA_WIDTH-1:0]         out_elements [0:NUM_MG-1][0:NUM_PE-1],
  output logic                          out_ctrl,
  output logic                          out_val,
  input  logic                          out_rdy,
  output logic [$clog2(NUM_MG+1)-1:0]   row_cnt
);

  localparam int CW = $clog2(NUM_MG + 1);
  localparam int RW = (NUM_MG > 1) ? $clog2(NUM_MG) : 1;

  typedef enum logic { FILLING = 1'b0, FULL  = 1'b1 } fill_state_t;
  typedef enum logic { EMPTY   = 1'b0, VALID = 1'b1 } out_state_t;

  fill_state_t fill_state;
  out_state_t  out_state;

  // ptr selects the fill bank; the other bank is the one presented downstream
  logic ptr;
  logic fill_flag;
  logic [DATA_WIDTH-1:0] mem [0:1][0:NUM_MG-1][0:NUM_PE-1];

  logic          accept;
  logic          last_row;
  logic          slot_free;
  logic          release_full;
  logic          xfer;
  logic          tile_flag;
  logic [RW-1:0] row_idx;

  assign in_rdy       = (fill_state == FILLING) && !flush;
  assign accept       = in_val && in_rdy;
  assign row_idx      = row_cnt[RW-1:0];
  assign out_val      = (out_state == VALID);
  assign slot_free    = !out_val || out_rdy;
  assign last_row     = accept && (row_cnt == CW'(NUM_MG - 1));
  assign release_full = (fill_state == FULL) && !flush && out_val && out_rdy;
  assign xfer         = (last_row && slot_free) || release_full;
  // Row 0 of the tile may be the completing row, so take its flag straight from the input
  assign tile_flag    = (row_cnt == '0) ? in_transpose : fill_flag;

  // Fill FSM, output FSM, bank pointer and presented flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_state <= FILLING;
      out_state  <= EMPTY;
      row_cnt    <= '0;
      ptr        <= 1'b0;
      fill_flag  <= 1'b0;
      out_ctrl   <= 1'b0;
    end else begin
      if (flush) begin
        fill_state <= FILLING;
        row_cnt    <= '0;
        fill_flag  <= 1'b0;
      end else if (xfer) begin
        fill_state <= FILLING;
        row_cnt    <= '0;
        fill_flag  <= 1'b0;
        ptr        <= ~ptr;
        out_ctrl   <= tile_flag;
      end else if (last_row) begin
        fill_state <= FULL;
        row_cnt    <= CW'(NUM_MG);
        fill_flag  <= tile_flag;
      end else if (accept) begin
        row_cnt <= row_cnt + CW'(1);
        if (row_cnt == '0) begin
          fill_flag <= in_transpose;
        end
      end

      if (xfer) begin
        out_state <= VALID;
      end else if (out_val && out_rdy) begin
        out_state <= EMPTY;
      end
    end
  end

  // Accepted rows land in the fill bank; storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < NUM_PE; j++) begin
        mem[ptr][row_idx][j] <= in_row[j];
      end
    end
  end

  // Present the non-fill bank; it cannot change until the pointer flips on a transfer
  always_comb begin
    for (int i = 0; i < NUM_MG; i++) begin
      for (int j = 0; j < NUM_PE; j++) begin
        out_elements[i][j] = mem[~ptr][i][j];
      end
    end
  end

endmodule

// File: tb/tb_matrix_tile_gather.sv
// tb/tb_matrix_tile_gather.sv - scoreboard bench for matrix_tile_gather
module tb_matrix_tile_gather;

  localparam int DW = 64;
  localparam int MG = 8;
  localparam int PE = 8;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic in_transpose;
  logic in_val;
  logic in_rdy;
  logic out_ctrl;
  logic out_val;
  logic out_rdy;
  logic [DW-1:0] in_row [0:PE-1];
  logic [DW-1:0] out_elements [0:MG-1][0:PE-1];
  logic [3:0] row_cnt;

  matrix_tile_gather #(.DATA_WIDTH(DW), .NUM_MG(MG), .NUM_PE(PE)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_row       (in_row),
    .in_transpose (in_transpose),
    .in_val       (in_val),
    .in_rdy       (in_rdy),
    .out_elements (out_elements),
    .out_ctrl     (out_ctrl),
    .out_val      (out_val),
    .out_rdy      (out_rdy),
    .row_cnt      (row_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] base;
    logic        ctrl;
  } tile_t;

  tile_t sb [$];
  int    pop_cyc [$];
  int    checks     = 0;
  int    errors     = 0;
  int    cycle      = 0;
  int    val_cycles = 0;
  int    stalls     = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cycle++;

  // Compare each tile the consumer takes against the oldest expected tile
  always @(negedge clk) begin : mon
    tile_t t;
    if (rst === 1'b1 && out_val === 1'b1) begin
      val_cycles++;
      if (out_rdy === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious_tile", 64'd1, 64'd0);
        end else begin
          t = sb.pop_front();
          pop_cyc.push_back(cycle);
          check("tile_e00",  out_elements[0][0], t.base);
          check("tile_e35",  out_elements[3][5], t.base + 64'h35);
          check("tile_e42",  out_elements[4][2], t.base + 64'h42);
          check("tile_e77",  out_elements[7][7], t.base + 64'h77);
          check("tile_ctrl", {63'd0, out_ctrl},  {63'd0, t.ctrl});
        end
      end
    end
  end

  // Drive rows first..first+n-1 of a tile; element [r][c] = base + r*16 + c
  task automatic send_rows(input logic [63:0] base, input logic tr0, input logic trr,
                           input int first, input int n);
    for (int r = first; r < first + n; r++) begin
      int w;
      for (int c = 0; c < PE; c++) in_row[c] = base + 64'(r * 16 + c);
      in_transpose = (r == 0) ? tr0 : trr;
      in_val = 1'b1;
      w = 0;
      @(negedge clk);
      while (!in_rdy && w < 50) begin
        stalls++;
        w++;
        @(negedge clk);
      end
      if (!in_rdy) check("in_rdy_timeout", 64'd0, 64'd1);
      if (r == MG - 1) sb.push_back('{base, tr0});
      @(posedge clk);
      #1;
    end
    in_val = 1'b0;
    in_transpose = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    in_val = 1'b0;
    in_transpose = 1'b0;
    out_rdy = 1'b1;
    for (int c = 0; c < PE; c++) in_row[c] = '0;

    #12;
    check("rst_row_cnt",  64'(row_cnt),      64'd0);
    check("rst_out_val",  {63'd0, out_val},  64'd0);
    check("rst_out_ctrl", {63'd0, out_ctrl}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("rst_in_rdy", {63'd0, in_rdy}, 64'd1);

    // Single tile: latency and content
    send_rows(64'h0, 1'b0, 1'b0, 0, 7);
    check("t1_pre_val", {63'd0, out_val}, 64'd0);
    send_rows(64'h0, 1'b0, 1'b0, 7, 1);
    check("t1_latency",  {63'd0, out_val},  64'd1);
    check("t1_ctrl",     {63'd0, out_ctrl}, 64'd0);
    check("t1_e35",      out_elements[3][5], 64'h35);
    drain();

    // Back-to-back tiles
    stalls = 0;
    val_cycles = 0;
    pop_cyc.delete();
    send_rows(64'h100, 1'b1, 1'b0, 0, 8);
    send_rows(64'h200, 1'b0, 1'b0, 0, 8);
    send_rows(64'h300, 1'b1, 1'b0, 0, 8);
    drain();
    check("t2_stalls",     64'(stalls),         64'd0);
    check("t2_pulses",     64'(pop_cyc.size()), 64'd3);
    check("t2_val_cycles", 64'(val_cycles),     64'd3);
    if (pop_cyc.size() == 3) begin
      check("t2_gap01", 64'(pop_cyc[1] - pop_cyc[0]), 64'd8);
      check("t2_gap12", 64'(pop_cyc[2] - pop_cyc[1]), 64'd8);
    end

    // Flag sampled only on row 0
    send_rows(64'h400, 1'b1, 1'b0, 0, 8);
    send_rows(64'h500, 1'b0, 1'b1, 0, 8);
    drain();

    // Backpressure: A held, B waits in FULL
    out_rdy = 1'b0;
    send_rows(64'h1000, 1'b0, 1'b0, 0, 8);
    send_rows(64'h2000, 1'b1, 1'b0, 0, 8);
    check("t4_full_in_rdy",  {63'd0, in_rdy},   64'd0);
    check("t4_full_row_cnt", 64'(row_cnt),      64'd8);
    check("t4_full_out_val", {63'd0, out_val},  64'd1);
    check("t4_full_a_e35",   out_elements[3][5], 64'h1035);
    repeat (3) @(posedge clk);
    #1;
    check("t4_hold_a_e35",  out_elements[3][5], 64'h1035);
    check("t4_hold_a_ctrl", {63'd0, out_ctrl},  64'd0);
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    out_rdy = 1'b0;
    check("t4_swap_out_val", {63'd0, out_val},  64'd1);
    check("t4_swap_b_e35",   out_elements[3][5], 64'h2035);
    check("t4_swap_b_ctrl",  {63'd0, out_ctrl}, 64'd1);
    check("t4_swap_in_rdy",  {63'd0, in_rdy},   64'd1);
    check("t4_swap_row_cnt", 64'(row_cnt),      64'd0);
    out_rdy = 1'b1;
    drain();

    // Flush a partial tile while a row is offered
    send_rows(64'h3000, 1'b1, 1'b1, 0, 5);
    check("t5_row_cnt_5", 64'(row_cnt), 64'd5);
    flush = 1'b1;
    in_val = 1'b1;
    for (int c = 0; c < PE; c++) in_row[c] = 64'hdead_0000 + 64'(c);
    @(negedge clk);
    check("t5_flush_in_rdy", {63'd0, in_rdy}, 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_val = 1'b0;
    check("t5_row_cnt_0", 64'(row_cnt), 64'd0);
    send_rows(64'h4000, 1'b0, 1'b0, 0, 8);
    drain();

    // Async reset mid-tile
    send_rows(64'h5000, 1'b0, 1'b0, 0, 3);
    #2;
    rst = 1'b0;
    #1;
    check("t6a_row_cnt", 64'(row_cnt),     64'd0);
    check("t6a_out_val", {63'd0, out_val}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("t6a_in_rdy", {63'd0, in_rdy}, 64'd1);

    // Async reset while a tile is presented
    out_rdy = 1'b0;
    send_rows(64'h6000, 1'b1, 1'b0, 0, 8);
    check("t6b_pre_out_val", {63'd0, out_val}, 64'd1);
    #2;
    rst = 1'b0;
    sb.delete();
    #1;
    check("t6b_out_val",  {63'd0, out_val},  64'd0);
    check("t6b_row_cnt",  64'(row_cnt),      64'd0);
    check("t6b_out_ctrl", {63'd0, out_ctrl}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_rdy = 1'b1;
    check("t6b_in_rdy", {63'd0, in_rdy}, 64'd1);
    send_rows(64'h7000, 1'b0, 1'b1, 0, 8);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
